blood_sample_scheduler: RTL and testbench

Time-shares the single combinational blood abnormality detector between NUM_REQ lab-station requesters. Each station's request is granted round-robin; the scheduler captures the station's bloodPH/bloodType and holds them on the detector inputs for SETTLE_CYCLES. It then samples the detector's abnormality flag and returns a tagged one-cycle response. It also keeps a saturating count of abnormal results. It sits at the top level beside the detector instance, between the station interfaces and the detector.

---
 rtl/blood_sample_scheduler_pkg.sv | 26 ++
 rtl/blood_sample_scheduler_rr_arbiter.sv | 39 +++
 rtl/blood_sample_scheduler.sv | 145 ++++++++++++++
 tb/tb_blood_sample_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/blood_sample_scheduler_pkg.sv
// Shared definitions for the blood sample scheduler.
// Holds the FSM state encoding, the detector data widths and a clog2 helper
// used to size index and counter fields.
package blood_sample_scheduler_pkg;

  localparam int unsigned PH_W   = 4;
  localparam int unsigned TYPE_W = 3;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StEval   = 2'd2,
    StReport = 2'd3
  } state_e;

  // Ceiling log2, never less than 1 so a field sized by it is always legal.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/blood_sample_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req upward starting at ptr+1 (wrapping) and returns the first set
// bit. The pointer itself is owned and updated by the scheduler.
// Ports:
//   req   - request vector, one bit per station
//   ptr   - index of the most recently served station
//   valid - at least one request is set
//   idx   - index of the winning station (0 when valid is low)
module blood_sample_scheduler_rr_arbiter
  import blood_sample_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  int unsigned base;

  // Offsets are scanned from farthest to nearest so the nearest hit is the
  // last assignment and therefore wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    base  = 32'(ptr);
    for (int unsigned off = NUM_REQ; off >= 1; off--) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req[i] && (((base + off) % NUM_REQ) == i)) begin
          valid = 1'b1;
          idx   = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/blood_sample_scheduler.sv
// Time-shares one combinational blood abnormality detector between NUM_REQ
// lab stations. A round-robin winner is granted for one cycle, its PH/type
// are captured and held on the detector inputs for SETTLE_CYCLES, then the
// detector flag is sampled and returned as a tagged one-cycle response.
// Abnormal results are tallied in a saturating counter.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   req/reqPH/reqType       - per-station request and packed data
//   gnt                     - one-hot, one-cycle grant
//   detPH/detType           - held inputs to the detector
//   detAbnormality          - detector result
//   respValid/respId/respAbnormal - one-cycle tagged response
//   abnCount/clrCount       - abnormal tally and its synchronous clear
//   busy                    - any state other than idle
module blood_sample_scheduler
  import blood_sample_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 8,
  localparam int unsigned ID_W = clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [PH_W*NUM_REQ-1:0]   reqPH,
  input  logic [TYPE_W*NUM_REQ-1:0] reqType,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [PH_W-1:0]           detPH,
  output logic [TYPE_W-1:0]         detType,
  input  logic                      detAbnormality,
  output logic                      respValid,
  output logic [ID_W-1:0]           respId,
  output logic                      respAbnormal,
  output logic [CNT_W-1:0]          abnCount,
  input  logic                      clrCount,
  output logic                      busy
);

  localparam int unsigned SET_W = clog2(SETTLE_CYCLES);

  state_e              state_q;
  logic [ID_W-1:0]     idx_q;
  logic [ID_W-1:0]     ptr_q;
  logic [PH_W-1:0]     ph_q;
  logic [TYPE_W-1:0]   type_q;
  logic [SET_W-1:0]    settle_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic                resp_valid_q;
  logic [ID_W-1:0]     resp_id_q;
  logic                resp_abn_q;
  logic [CNT_W-1:0]    abn_cnt_q;

  logic                arb_valid;
  logic [ID_W-1:0]     arb_idx;
  logic [PH_W-1:0]     sel_ph;
  logic [TYPE_W-1:0]   sel_type;

  blood_sample_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  // Data of the station currently being loaded.
  always_comb begin
    sel_ph   = '0;
    sel_type = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (idx_q == ID_W'(i)) begin
        sel_ph   = reqPH[i*PH_W +: PH_W];
        sel_type = reqType[i*TYPE_W +: TYPE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      ptr_q        <= ID_W'(NUM_REQ - 1);
      ph_q         <= '0;
      type_q       <= '0;
      settle_q     <= '0;
      gnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_abn_q   <= 1'b0;
      abn_cnt_q    <= '0;
    end else begin
      gnt_q        <= '0;
      resp_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (arb_valid) begin
            idx_q   <= arb_idx;
            gnt_q   <= NUM_REQ'(1) << arb_idx;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          ph_q     <= sel_ph;
          type_q   <= sel_type;
          settle_q <= SET_W'(SETTLE_CYCLES - 1);
          state_q  <= StEval;
        end
        StEval: begin
          if (settle_q == '0) begin
            resp_abn_q   <= detAbnormality;
            resp_valid_q <= 1'b1;
            resp_id_q    <= idx_q;
            state_q      <= StReport;
          end else begin
            settle_q <= settle_q - SET_W'(1);
          end
        end
        StReport: begin
          ptr_q   <= idx_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // Clear takes precedence over a coincident report increment.
      if (clrCount) begin
        abn_cnt_q <= '0;
      end else if ((state_q == StReport) && resp_abn_q && (abn_cnt_q != '1)) begin
        abn_cnt_q <= abn_cnt_q + CNT_W'(1);
      end
    end
  end

  assign gnt          = gnt_q;
  assign detPH        = ph_q;
  assign detType      = type_q;
  assign respValid    = resp_valid_q;
  assign respId       = resp_id_q;
  assign respAbnormal = resp_abn_q;
  assign abnCount     = abn_cnt_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_blood_sample_scheduler.sv
// Self-checking bench for blood_sample_scheduler. A transaction-level model
// tracks time since grant, the round-robin pointer and the tally, and every
// cycle's outputs are compared against it.
module tb_blood_sample_scheduler;

  localparam int N  = 4;
  localparam int S  = 2;
  localparam int CW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [4*N-1:0] reqPH;
  logic [3*N-1:0] reqType;
  logic [N-1:0]   gnt;
  logic [3:0]     detPH;
  logic [2:0]     detType;
  logic           det_abn;
  logic           respValid;
  logic [1:0]     respId;
  logic           respAbnormal;
  logic [CW-1:0]  abnCount;
  logic           clrCount;
  logic           busy;

  logic force_en, force_val, auto_drop;

  int errors = 0;
  int checks = 0;

  // Model: m_t = -1 idle, 0 grant cycle, 1..S settle, S+1 response cycle.
  int         m_t, m_id, m_ptr, m_cnt;
  logic [3:0] m_ph;
  logic [2:0] m_type;
  logic       m_abn;

  always #5 clk = ~clk;

  // Detector stand-in: parity of its inputs unless overridden.
  always_comb det_abn = force_en ? force_val : ^{detPH, detType};

  blood_sample_scheduler #(
    .NUM_REQ       (N),
    .SETTLE_CYCLES (S),
    .CNT_W         (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .reqPH          (reqPH),
    .reqType        (reqType),
    .gnt            (gnt),
    .detPH          (detPH),
    .detType        (detType),
    .detAbnormality (det_abn),
    .respValid      (respValid),
    .respId         (respId),
    .respAbnormal   (respAbnormal),
    .abnCount       (abnCount),
    .clrCount       (clrCount),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int o = 1; o <= N; o++) begin
      if (((r >> ((p + o) % N)) & 1) != 0) return (p + o) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_t = -1; m_id = 0; m_ptr = N - 1; m_cnt = 0;
    m_ph = '0; m_type = '0; m_abn = 1'b0;
  endtask

  task automatic check_all();
    chk("gnt", 32'(gnt), (m_t == 0) ? (32'd1 << m_id) : 32'd0);
    chk("busy", 32'(busy), 32'(m_t != -1));
    chk("respValid", 32'(respValid), 32'(m_t == S + 1));
    chk("respAbnormal", 32'(respAbnormal), 32'(m_abn));
    chk("detPH", 32'(detPH), 32'(m_ph));
    chk("detType", 32'(detType), 32'(m_type));
    chk("abnCount", 32'(abnCount), 32'(m_cnt));
    if (m_t == S + 1) chk("respId", 32'(respId), 32'(m_id));
  endtask

  task automatic set_station(input int i, input logic [3:0] ph, input logic [2:0] ty);
    reqPH[4*i +: 4]   = ph;
    reqType[3*i +: 3] = ty;
  endtask

  // One clock: advance the model from the pre-edge inputs, then compare.
  task automatic step();
    int  nt, ncnt;
    bit  granted;
    nt      = m_t;
    ncnt    = m_cnt;
    granted = (m_t == 0);
    if (clrCount) ncnt = 0;
    else if (m_t == S + 1 && m_abn && m_cnt < (1 << CW) - 1) ncnt = m_cnt + 1;
    if (m_t == -1) begin
      if (pick(req, m_ptr) >= 0) begin
        m_id = pick(req, m_ptr);
        nt   = 0;
      end
    end else if (m_t == 0) begin
      m_ph   = reqPH[4*m_id +: 4];
      m_type = reqType[3*m_id +: 3];
      nt     = 1;
    end else if (m_t < S) begin
      nt = m_t + 1;
    end else if (m_t == S) begin
      m_abn = force_en ? force_val : ^{m_ph, m_type};
      nt    = S + 1;
    end else begin
      m_ptr = m_id;
      nt    = -1;
    end
    @(posedge clk);
    #1;
    m_t   = nt;
    m_cnt = ncnt;
    if (granted && auto_drop) req[m_id] = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int  order[$];
    int  when[$];
    int  v;
    bit  done;
    rst_n = 1'b0; req = '0; reqPH = '0; reqType = '0; clrCount = 1'b0;
    force_en = 1'b0; force_val = 1'b0; auto_drop = 1'b1;
    do_reset();

    // Single request on station 2, PH 7 -> abnormal by parity.
    set_station(2, 4'd7, 3'd0);
    req = 4'b0100;
    repeat (6) step();
    chk("single_count", 32'(abnCount), 32'd1);

    // Idle stability.
    req = '0;
    repeat (20) step();

    // Fairness with all stations requesting continuously.
    do_reset();
    for (int i = 0; i < N; i++) set_station(i, 4'($urandom), 3'($urandom));
    auto_drop = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 25; k++) begin
      step();
      if (respValid === 1'b1) begin
        order.push_back(int'(respId));
        when.push_back(k);
      end
    end
    chk("fair_count", 32'(order.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      v = (i < order.size()) ? order[i] : -1;
      chk("fair_order", 32'(v), 32'(i % N));
      if (i > 0) begin
        v = (i < when.size()) ? when[i] - when[i-1] : -1;
        chk("fair_spacing", 32'(v), 32'(S + 3));
      end
    end

    // Saturation with every result abnormal, then clear during a report.
    req = '0;
    repeat (6) step();
    force_en = 1'b1; force_val = 1'b1;
    req = 4'b0001;
    repeat (26) step();
    chk("sat_count", 32'(abnCount), 32'd3);
    done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (m_t == S + 1 && !done) begin
        clrCount = 1'b1;
        step();
        clrCount = 1'b0;
        done = 1'b1;
        chk("clr_wins", 32'(abnCount), 32'd0);
      end else begin
        step();
      end
    end
    chk("clr_seen", 32'(done), 32'd1);
    req = '0;
    auto_drop = 1'b1;
    repeat (6) step();

    // Detector flag rising in the last settle cycle is captured; rising after it is not.
    for (int c = 0; c < 2; c++) begin
      set_station(1, 4'd3, 3'd5);
      req = 4'b0010;
      for (int k = 0; k < 6; k++) begin
        force_val = (m_t != -1) && (m_t >= ((c == 0) ? 2 : S + 1));
        step();
        if (m_t == S + 1) chk("sample_point", 32'(respAbnormal), (c == 0) ? 32'd1 : 32'd0);
      end
      req = '0;
      force_val = 1'b0;
      repeat (3) step();
    end
    force_en = 1'b0;

    // Reset during settle abandons the job and restores the pointer.
    set_station(1, 4'd9, 3'd2);
    req = 4'b0010;
    repeat (2) step();
    chk("mid_in_eval", 32'(m_t), 32'd1);
    do_reset();
    set_station(3, 4'd5, 3'd6);
    req = 4'b1000;
    for (int k = 0; k < 6; k++) begin
      step();
      if (m_t == S + 1) chk("post_reset_id", 32'(respId), 32'd3);
    end

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(3) == 0) begin
          set_station(i, 4'($urandom), 3'($urandom));
          req[i] = 1'b1;
        end
      end
      clrCount = ($urandom_range(15) == 0);
      step();
    end
    clrCount = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
